aes_dec_ctrl: RTL and testbench
===============================

Name: aes_dec_ctrl

Overview:
Control FSM for the AES decryption datapath (aes_dec) and the reverse key schedule.
- Accepts an aes_pkg::opcode with a start strobe.
- Sequences the inverse-round stages: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- Drives the backward key-stepping control to the key generator.
- Signals completion with a one-cycle ready pulse.
- Supports single-round ops (AESDEC, AESDECLAST, AESIMC) and a full NR-round decryption (AESDECFULL).

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256).
ROUND_W, 4, width of the round index output; must satisfy 2**ROUND_W > NR.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  request strobe; sampled only in IDLE.
opcode_i  in  aes_pkg::opcode  operation; sampled with start_i.
load_o  out  1  datapath latches input state/key.
inv_shift_o  out  1  enable InvShiftRows.
inv_sub_o  out  1  enable InvSubBytes.
add_key_o  out  1  enable AddRoundKey.
inv_mix_o  out  1  enable InvMixColumns.
key_sel_o  out  1  0 = external round key, 1 = key-generator output.
key_rev_o  out  1  key generator steps one round backward this cycle.
round_o  out  ROUND_W  current round index for Rcon lookup.
busy_o  out  1  operation in progress.
cipher_ready_o  out  1  one-cycle pulse; result valid.
err_o  out  1  one-cycle pulse; unsupported opcode rejected.

Behaviour:
- Reset: state IDLE, latched opcode NOOP, round counter 0. All outputs 0 while rst is high and in the cycle after release.
- All outputs are Moore-decoded from the registered state, latched opcode and round counter. There are no combinational paths from start_i or opcode_i to outputs.
- States: IDLE, LOAD, INV_RND, LAST_RND, IMC, DONE.
- IDLE, start_i=1:
  - AESDEC, AESDECLAST, AESIMC or AESDECFULL: latch the opcode, go to LOAD.
  - NOOP: stay in IDLE, no error.
  - Any other value (AESENC, AESENCLAST, AESKEYGENASSIST, unused): stay in IDLE, err_o=1 in the next cycle only.
- start_i and opcode_i are ignored in every state other than IDLE, including DONE. The latched opcode holds until the next accept.
- LOAD: load_o=1, busy_o=1. Next state by opcode:
  - AESDEC: INV_RND.
  - AESDECLAST: LAST_RND.
  - AESIMC: IMC.
  - AESDECFULL: also add_key_o=1, key_sel_o=1, round_o=NR (initial AddRoundKey); counter loads NR-1; next INV_RND.
- INV_RND: inv_shift_o=inv_sub_o=add_key_o=inv_mix_o=1, busy_o=1.
  - AESDEC: key_sel_o=0, round_o=0; next DONE.
  - AESDECFULL: key_sel_o=1, key_rev_o=1, round_o=counter. Decrement the counter each cycle. Stay while counter>1; when counter==1, next LAST_RND (counter becomes 0).
- LAST_RND: inv_shift_o=inv_sub_o=add_key_o=1, inv_mix_o=0, busy_o=1.
  - AESDECFULL: key_sel_o=1, key_rev_o=1, round_o=0.
  - AESDECLAST: key_sel_o=0, key_rev_o=0.
  - Next DONE.
- IMC: inv_mix_o=1 only, busy_o=1; next DONE.
- DONE: cipher_ready_o=1, busy_o=1, all stage enables 0; next IDLE.
- Latency, with the accept edge as cycle 0, measured to the cycle cipher_ready_o is high:
  - AESDEC, AESDECLAST, AESIMC: 3 cycles.
  - AESDECFULL: NR+2 cycles.
  - busy_o is high from cycle 1 through the ready cycle inclusive.
- Back-to-back operation: earliest next accept is the first IDLE cycle after DONE. Throughput is 1 op per 4 cycles for single ops.
- Counter arithmetic: unsigned ROUND_W bits, never wraps. The decrement applies only in INV_RND with AESDECFULL.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No cipher_ready_o or err_o pulse is generated for the aborted op.
- A start_i pulse coincident with reset release is ignored.

Test Plan:
1. Reset, then hold IDLE with no start -> all outputs 0, round_o=0, for 5 cycles.
2. start_i with AESDEC at cycle 0 -> load_o at cycle 1; all four enables at cycle 2 with key_sel_o=0; cipher_ready_o only at cycle 3; busy_o high cycles 1-3.
3. AESDECLAST, then AESIMC back-to-back, second started in the first IDLE cycle -> each ready 3 cycles after its accept. AESDECLAST: inv_mix_o=0 in its round cycle. AESIMC: only inv_mix_o in its round cycle.
4. AESDECFULL, NR=10 -> round_o sequence 10,9,8,...,1,0 over cycles 1-11; key_rev_o high cycles 2-11; inv_mix_o low at cycle 11; cipher_ready_o at cycle 12. With NR=14, ready at cycle 16.
5. AESENC with start_i in IDLE -> err_o one cycle, busy_o stays 0. start_i with AESDEC during busy (cycles 1-3) -> ignored, exactly one ready pulse.
6. Assert rst at cycle 5 of AESDECFULL -> outputs 0 asynchronously, no ready pulse. A fresh AESDEC afterwards completes normally in 3 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES opcode encoding.
// opcode is a plain 4-bit vector, so codes 8..15 exist and are treated as
// unsupported by the controllers.
package aes_pkg;

    typedef logic [3:0] opcode;

    localparam opcode NOOP            = 4'd0;
    localparam opcode AESENC          = 4'd1;
    localparam opcode AESENCLAST      = 4'd2;
    localparam opcode AESDEC          = 4'd3;
    localparam opcode AESDECLAST      = 4'd4;
    localparam opcode AESIMC          = 4'd5;
    localparam opcode AESKEYGENASSIST = 4'd6;
    localparam opcode AESDECFULL      = 4'd7;

endpackage

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: control FSM for the AES decryption datapath and the reverse
// key schedule.
//
// Supported operations:
//   - single inverse rounds: AESDEC, AESDECLAST, AESIMC
//   - a full NR-round decryption: AESDECFULL
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         request strobe, only sampled in IDLE
//   opcode_i        operation, sampled with start_i
//   load_o          datapath latches input state/key
//   inv_shift_o     InvShiftRows enable
//   inv_sub_o       InvSubBytes enable
//   add_key_o       AddRoundKey enable
//   inv_mix_o       InvMixColumns enable
//   key_sel_o       0 = external round key, 1 = key-generator output
//   key_rev_o       key generator steps one round backward
//   round_o         round index for Rcon lookup
//   busy_o          operation in progress
//   cipher_ready_o  one-cycle result-valid pulse
//   err_o           one-cycle pulse for a rejected opcode
//
// All outputs are decoded from registered state only.
module aes_dec_ctrl #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  aes_pkg::opcode     opcode_i,
    output logic               load_o,
    output logic               inv_shift_o,
    output logic               inv_sub_o,
    output logic               add_key_o,
    output logic               inv_mix_o,
    output logic               key_sel_o,
    output logic               key_rev_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               busy_o,
    output logic               cipher_ready_o,
    output logic               err_o
);
    import aes_pkg::*;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_INV  = 3'd2;
    localparam logic [2:0] S_LAST = 3'd3;
    localparam logic [2:0] S_IMC  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [ROUND_W-1:0] NR_R    = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] NR_M1_R = ROUND_W'(NR - 1);

    logic [2:0]         state_reg, state_next;
    opcode              op_reg, op_next;
    logic [ROUND_W-1:0] cnt_reg, cnt_next;
    logic               err_reg, err_next;
    // Low for the first edge after reset release, so a start strobe that
    // coincides with the release is not accepted.
    logic               arm_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= NOOP;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            arm_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            arm_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i && arm_reg) begin
                    case (opcode_i)
                        AESDEC, AESDECLAST, AESIMC, AESDECFULL: begin
                            op_next    = opcode_i;
                            state_next = S_LOAD;
                        end
                        NOOP:    ;
                        default: err_next = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                case (op_reg)
                    AESDECLAST: state_next = S_LAST;
                    AESIMC:     state_next = S_IMC;
                    AESDECFULL: begin
                        cnt_next   = NR_M1_R;
                        state_next = S_INV;
                    end
                    default:    state_next = S_INV;
                endcase
            end
            S_INV: begin
                if (op_reg == AESDECFULL) begin
                    // Counter saturates at zero rather than wrapping.
                    if (cnt_reg != '0)
                        cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg <= 1)
                        state_next = S_LAST;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_LAST:  state_next = S_DONE;
            S_IMC:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_o         = 1'b0;
        inv_shift_o    = 1'b0;
        inv_sub_o      = 1'b0;
        add_key_o      = 1'b0;
        inv_mix_o      = 1'b0;
        key_sel_o      = 1'b0;
        key_rev_o      = 1'b0;
        round_o        = '0;
        busy_o         = 1'b0;
        cipher_ready_o = 1'b0;
        err_o          = err_reg;
        case (state_reg)
            S_LOAD: begin
                load_o = 1'b1;
                busy_o = 1'b1;
                if (op_reg == AESDECFULL) begin
                    // Initial AddRoundKey with the last round key.
                    add_key_o = 1'b1;
                    key_sel_o = 1'b1;
                    round_o   = NR_R;
                end
            end
            S_INV: begin
                inv_shift_o = 1'b1;
                inv_sub_o   = 1'b1;
                add_key_o   = 1'b1;
                inv_mix_o   = 1'b1;
                busy_o      = 1'b1;
                if (op_reg == AESDECFULL) begin
                    key_sel_o = 1'b1;
                    key_rev_o = 1'b1;
                    round_o   = cnt_reg;
                end
            end
            S_LAST: begin
                inv_shift_o = 1'b1;
                inv_sub_o   = 1'b1;
                add_key_o   = 1'b1;
                busy_o      = 1'b1;
                if (op_reg == AESDECFULL) begin
                    key_sel_o = 1'b1;
                    key_rev_o = 1'b1;
                end
            end
            S_IMC: begin
                inv_mix_o = 1'b1;
                busy_o    = 1'b1;
            end
            S_DONE: begin
                cipher_ready_o = 1'b1;
                busy_o         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: directed bench for aes_dec_ctrl (NR=10 and NR=14 instances).
// Output vector bit order: load shift sub add mix ksel krev busy ready err.
module tb_aes_dec_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start14 = 1'b0;
    opcode op = NOOP;

    always #5 clk = ~clk;

    logic       load, shift, sub, addk, mix, ksel, krev, busy, ready, err;
    logic [3:0] rnd;
    logic       load14, shift14, sub14, addk14, mix14, ksel14, krev14, busy14, ready14, err14;
    logic [3:0] rnd14;

    aes_dec_ctrl #(.NR(10), .ROUND_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start), .opcode_i(op),
        .load_o(load), .inv_shift_o(shift), .inv_sub_o(sub), .add_key_o(addk),
        .inv_mix_o(mix), .key_sel_o(ksel), .key_rev_o(krev), .round_o(rnd),
        .busy_o(busy), .cipher_ready_o(ready), .err_o(err)
    );

    aes_dec_ctrl #(.NR(14), .ROUND_W(4)) dut14 (
        .clk(clk), .rst(rst), .start_i(start14), .opcode_i(op),
        .load_o(load14), .inv_shift_o(shift14), .inv_sub_o(sub14), .add_key_o(addk14),
        .inv_mix_o(mix14), .key_sel_o(ksel14), .key_rev_o(krev14), .round_o(rnd14),
        .busy_o(busy14), .cipher_ready_o(ready14), .err_o(err14)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {load, shift, sub, addk, mix, ksel, krev, busy, ready, err};
    endfunction

    // Compare the current cycle, then move to the next sample point.
    task automatic expect_cyc(input string tag, input logic [9:0] v, input logic [3:0] r);
        chk(tag, 32'(outs()), 32'(v));
        chk({tag, "_rnd"}, 32'(rnd), 32'(r));
        $display("cycle %s outs=%b rnd=%0d", tag, outs(), rnd);
        @(posedge clk); #1;
    endtask

    // Present a request before the accept edge; returns at cycle 1 sample point.
    task automatic accept(input opcode o);
        op = o;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_LOAD   = 10'b1000000100;
    localparam logic [9:0] V_DEC    = 10'b0111100100;
    localparam logic [9:0] V_LAST   = 10'b0111000100;
    localparam logic [9:0] V_IMC    = 10'b0000100100;
    localparam logic [9:0] V_DONE   = 10'b0000000110;
    localparam logic [9:0] V_FLOAD  = 10'b1001010100;
    localparam logic [9:0] V_FINV   = 10'b0111111100;
    localparam logic [9:0] V_FLAST  = 10'b0111011100;
    localparam logic [9:0] V_ERR    = 10'b0000000001;

    int cnt;
    int lat;

    initial begin
        // 1: reset and idle
        #1;
        chk("rst_outs", 32'(outs()), 32'(V_IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) expect_cyc($sformatf("idle%0d", i), V_IDLE, 4'd0);

        // 2: AESDEC
        accept(AESDEC);
        expect_cyc("dec_c1", V_LOAD, 4'd0);
        expect_cyc("dec_c2", V_DEC, 4'd0);
        expect_cyc("dec_c3", V_DONE, 4'd0);
        // cycle 4 is IDLE: start AESDECLAST here, then AESIMC in its first IDLE
        chk("dec_c4", 32'(outs()), 32'(V_IDLE));
        accept(AESDECLAST);
        expect_cyc("last_c1", V_LOAD, 4'd0);
        expect_cyc("last_c2", V_LAST, 4'd0);
        expect_cyc("last_c3", V_DONE, 4'd0);
        chk("last_c4", 32'(outs()), 32'(V_IDLE));
        accept(AESIMC);
        expect_cyc("imc_c1", V_LOAD, 4'd0);
        expect_cyc("imc_c2", V_IMC, 4'd0);
        expect_cyc("imc_c3", V_DONE, 4'd0);
        expect_cyc("imc_c4", V_IDLE, 4'd0);

        // 4: AESDECFULL NR=10
        accept(AESDECFULL);
        expect_cyc("full_c1", V_FLOAD, 4'd10);
        for (int k = 2; k <= 10; k++)
            expect_cyc($sformatf("full_c%0d", k), V_FINV, 4'(11 - k));
        expect_cyc("full_c11", V_FLAST, 4'd0);
        expect_cyc("full_c12", V_DONE, 4'd0);
        expect_cyc("full_c13", V_IDLE, 4'd0);

        // 4b: AESDECFULL NR=14, ready latency
        op = AESDECFULL; start14 = 1'b1;
        @(posedge clk); #1;
        start14 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (ready14) lat = c;
            else begin @(posedge clk); #1; end
        end
        chk("full14_lat", 32'(lat), 32'd16);
        $display("nr14 ready latency=%0d", lat);
        @(posedge clk); #1;

        // 5: rejected opcode
        accept(AESENC);
        expect_cyc("enc_c1", V_ERR, 4'd0);
        expect_cyc("enc_c2", V_IDLE, 4'd0);
        accept(4'd12);
        expect_cyc("unused_c1", V_ERR, 4'd0);
        accept(NOOP);
        expect_cyc("noop_c1", V_IDLE, 4'd0);

        // 5b: start held during busy is ignored
        accept(AESDEC);
        start = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            if (ready) cnt++;
            chk($sformatf("busyhold_c%0d", c), 32'(busy), 32'd1);
            if (c == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        for (int c = 4; c <= 8; c++) begin
            if (ready) cnt++;
            chk($sformatf("busyhold_idle%0d", c), 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        chk("busyhold_readies", 32'(cnt), 32'd1);

        // 6: reset mid-AESDECFULL
        accept(AESDECFULL);
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_c5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outs", 32'(outs()), 32'(V_IDLE));
        chk("abort_rnd", 32'(rnd), 32'd0);
        repeat (2) @(posedge clk);
        // release with a coincident start: must be ignored
        @(negedge clk);
        rst = 1'b0; op = AESDEC; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rel_outs", 32'(outs()), 32'(V_IDLE));
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (ready || busy) cnt++;
            @(posedge clk); #1;
        end
        chk("rel_no_activity", 32'(cnt), 32'd0);
        accept(AESDEC);
        expect_cyc("post_c1", V_LOAD, 4'd0);
        expect_cyc("post_c2", V_DEC, 4'd0);
        expect_cyc("post_c3", V_DONE, 4'd0);
        expect_cyc("post_c4", V_IDLE, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
